// File: rtl/bus_grant_ctrl_if.sv
// Grant controller bus: raw requests, generator handshake, grant outputs.
// slave = controller side, master = requester/generator side.
interface bus_grant_ctrl_if;
  logic [7:0] req;
  logic [7:0] pri_req;
  logic       pri_en;
  logic [7:0] pri_onehot;
  logic [7:0] gnt;
  logic [2:0] owner;
  logic       bus_busy;
  logic       timeout_err;

  modport slave (
    input  req,
    input  pri_onehot,
    output pri_req,
    output pri_en,
    output gnt,
    output owner,
    output bus_busy,
    output timeout_err
  );

  modport master (
    output req,
    output pri_onehot,
    input  pri_req,
    input  pri_en,
    input  gnt,
    input  owner,
    input  bus_busy,
    input  timeout_err
  );
endinterface

// File: rtl/bus_grant_ctrl.sv
// Bus grant controller: masks locked masters, strobes the priority
// generator, validates its one-hot result and holds the grant.
// Ports: clk, reset (sync, active-high), bus (slave modport).
module bus_grant_ctrl #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic reset,
  bus_grant_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_CHECK,
    S_OWNED,
    S_RELEASE
  } state_t;

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TMO_LAST =
    TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           r_state, w_state_nx;
  logic [7:0]       r_lock, w_lock_nx;
  logic [7:0]       r_gnt, w_gnt_nx;
  logic [2:0]       r_owner, w_owner_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_busy, w_busy_nx;
  logic             r_terr, w_terr_nx;

  logic [7:0] w_pri_req;
  logic       w_onehot;
  logic       w_valid;
  logic [2:0] w_idx;
  logic       w_own_req;
  logic       w_tmo;

  assign w_pri_req = bus.req & ~r_lock;

  // x & (x-1) clears the lowest set bit: zero iff at most one bit set
  assign w_onehot = (bus.pri_onehot != 8'd0) &&
    ((bus.pri_onehot & (bus.pri_onehot - 8'd1)) == 8'd0);
  assign w_valid = w_onehot &&
    ((bus.pri_onehot & w_pri_req) != 8'd0);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < 8; i++)
      if (bus.pri_onehot[i]) w_idx = 3'(i);
  end

  assign w_own_req = bus.req[r_owner];
  assign w_tmo     = TMO_EN && (r_cnt == TMO_LAST);

  always_comb begin
    w_state_nx = r_state;
    w_gnt_nx   = r_gnt;
    w_owner_nx = r_owner;
    w_cnt_nx   = r_cnt;
    w_terr_nx  = 1'b0;
    w_lock_nx  = r_lock & bus.req;
    unique case (r_state)
      S_IDLE: begin
        if (|w_pri_req) w_state_nx = S_SAMPLE;
      end
      S_SAMPLE: begin
        w_state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (w_valid) begin
          w_gnt_nx   = bus.pri_onehot;
          w_owner_nx = w_idx;
          w_cnt_nx   = '0;
          w_state_nx = S_OWNED;
        end else begin
          w_state_nx = S_IDLE;
        end
      end
      S_OWNED: begin
        if (r_cnt != CNT_MAX) w_cnt_nx = r_cnt + CNT_ONE;
        // voluntary release outranks a coincident timeout
        if (!w_own_req) begin
          w_gnt_nx   = '0;
          w_state_nx = S_RELEASE;
        end else if (w_tmo) begin
          w_gnt_nx           = '0;
          w_terr_nx          = 1'b1;
          w_lock_nx[r_owner] = 1'b1;
          w_state_nx         = S_RELEASE;
        end
      end
      S_RELEASE: begin
        w_gnt_nx   = '0;
        w_state_nx = S_IDLE;
      end
      default: begin
        w_gnt_nx   = '0;
        w_state_nx = S_IDLE;
      end
    endcase
    w_busy_nx = (w_state_nx == S_CHECK) ||
                (w_state_nx == S_OWNED) ||
                (w_state_nx == S_RELEASE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_lock  <= '0;
      r_gnt   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_terr  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_lock  <= w_lock_nx;
      r_gnt   <= w_gnt_nx;
      r_owner <= w_owner_nx;
      r_cnt   <= w_cnt_nx;
      r_busy  <= w_busy_nx;
      r_terr  <= w_terr_nx;
    end
  end

  assign bus.pri_req     = w_pri_req;
  assign bus.pri_en      = (r_state == S_SAMPLE);
  assign bus.gnt         = r_gnt;
  assign bus.owner       = r_owner;
  assign bus.bus_busy    = r_busy;
  assign bus.timeout_err = r_terr;

endmodule

// File: tb/tb_bus_grant_ctrl.sv
// Testbench for bus_grant_ctrl with a behavioural priority generator
// and a transaction-level expectation model.
module tb_bus_grant_ctrl;
  localparam int TMO = 4;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  logic [7:0] tb_lock = '0;
  logic [7:0] gen_q = '0;
  logic       force_on = 1'b0;
  logic [7:0] force_val = '0;

  bus_grant_ctrl_if bus ();

  bus_grant_ctrl #(
    .TIMEOUT_CYCLES(TMO),
    .CNT_W         (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // generator: registered lowest-index-wins on enable
  always @(posedge clk)
    if (bus.pri_en) gen_q <= bus.pri_req & (~bus.pri_req + 8'd1);

  assign bus.pri_onehot = force_on ? force_val : gen_q;

  function automatic logic [2:0] idx_of(input logic [7:0] v);
    idx_of = '0;
    for (int i = 0; i < 8; i++) if (v[i]) idx_of = 3'(i);
  endfunction

  // one clock; lockout model: a bit survives only while its req is high
  task automatic step();
    logic [7:0] nl;
    nl = tb_lock & bus.req;
    @(posedge clk);
    tb_lock = reset ? 8'h00 : nl;
    #1;
  endtask

  task automatic test_reset();
    bus.req = 8'h00;
    reset = 1'b1;
    step(); step();
    checks++;
    if (bus.gnt !== 8'h00) begin
      errors++; $display("FAIL reset_gnt: got %h want 00", bus.gnt);
    end
    checks++;
    if (bus.owner !== 3'd0) begin
      errors++; $display("FAIL reset_owner: got %0d want 0", bus.owner);
    end
    checks++;
    if (bus.bus_busy !== 1'b0 || bus.timeout_err !== 1'b0 ||
        bus.pri_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b terr=%b en=%b want 0 0 0",
               bus.bus_busy, bus.timeout_err, bus.pri_en);
    end
    reset = 1'b0;
    bus.req = 8'h5A;
    #1;
    checks++;
    if (bus.pri_req !== 8'h5A) begin
      errors++; $display("FAIL reset_lockout: got %h want 5A", bus.pri_req);
    end
    bus.req = 8'h00;
    step();
  endtask

  task automatic test_single();
    bus.req = 8'h04;
    step();
    checks++;
    if (bus.pri_en !== 1'b1 || bus.gnt !== 8'h00) begin
      errors++;
      $display("FAIL single_sample: en=%b gnt=%h want 1 00",
               bus.pri_en, bus.gnt);
    end
    step();
    checks++;
    if (bus.pri_en !== 1'b0 || bus.bus_busy !== 1'b1 ||
        bus.gnt !== 8'h00) begin
      errors++;
      $display("FAIL single_check: en=%b busy=%b gnt=%h want 0 1 00",
               bus.pri_en, bus.bus_busy, bus.gnt);
    end
    step();
    checks++;
    if (bus.gnt !== 8'h04 || bus.owner !== 3'd2) begin
      errors++;
      $display("FAIL single_grant: gnt=%h owner=%0d want 04 2",
               bus.gnt, bus.owner);
    end
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL single_release: gnt=%h busy=%b want 00 1",
               bus.gnt, bus.bus_busy);
    end
    step();
    checks++;
    if (bus.bus_busy !== 1'b0 || bus.owner !== 3'd2) begin
      errors++;
      $display("FAIL single_idle: busy=%b owner=%0d want 0 2",
               bus.bus_busy, bus.owner);
    end
  endtask

  task automatic test_simultaneous();
    bus.req = 8'hA6;
    step(); step(); step();
    checks++;
    if (bus.gnt !== 8'h02 || bus.owner !== 3'd1) begin
      errors++;
      $display("FAIL simul_grant: gnt=%h owner=%0d want 02 1",
               bus.gnt, bus.owner);
    end
    bus.req = 8'hA4;
    step();
    checks++;
    if (bus.gnt !== 8'h00) begin
      errors++; $display("FAIL simul_dead: gnt=%h want 00", bus.gnt);
    end
    step();
    step();
    checks++;
    if (bus.pri_en !== 1'b1) begin
      errors++; $display("FAIL simul_resample: en=%b want 1", bus.pri_en);
    end
    step();
    step();
    checks++;
    if (bus.gnt !== 8'h04 || bus.owner !== 3'd2) begin
      errors++;
      $display("FAIL simul_next: gnt=%h owner=%0d want 04 2",
               bus.gnt, bus.owner);
    end
    bus.req = 8'h00;
    step(); step();
  endtask

  task automatic test_timeout();
    int n;
    bus.req = 8'h09;
    step(); step(); step();
    n = 0;
    while (bus.gnt === 8'h01 && n < 20) begin
      n++;
      step();
    end
    checks++;
    if (n != TMO) begin
      errors++; $display("FAIL tmo_hold: got %0d cycles want %0d", n, TMO);
    end
    checks++;
    if (bus.timeout_err !== 1'b1 || bus.gnt !== 8'h00) begin
      errors++;
      $display("FAIL tmo_pulse: terr=%b gnt=%h want 1 00",
               bus.timeout_err, bus.gnt);
    end
    tb_lock[0] = 1'b1;
    checks++;
    if (bus.pri_req !== (8'h09 & ~tb_lock)) begin
      errors++;
      $display("FAIL tmo_lockout: got %h want %h",
               bus.pri_req, 8'h09 & ~tb_lock);
    end
    step();
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after: terr=%b busy=%b want 0 0",
               bus.timeout_err, bus.bus_busy);
    end
    step(); step(); step();
    checks++;
    if (bus.gnt !== 8'h08 || bus.owner !== 3'd3) begin
      errors++;
      $display("FAIL tmo_next: gnt=%h owner=%0d want 08 3",
               bus.gnt, bus.owner);
    end
    bus.req = 8'h08;
    step();
    bus.req = 8'h09;
    #1;
    checks++;
    if (bus.pri_req !== 8'h09) begin
      errors++; $display("FAIL tmo_unlock: got %h want 09", bus.pri_req);
    end
    bus.req = 8'h01;
    step(); step(); step(); step(); step();
    checks++;
    if (bus.gnt !== 8'h01 || bus.owner !== 3'd0) begin
      errors++;
      $display("FAIL tmo_regrant: gnt=%h owner=%0d want 01 0",
               bus.gnt, bus.owner);
    end
    bus.req = 8'h00;
    step(); step();
  endtask

  task automatic test_release_at_timeout();
    bus.req = 8'h01;
    step(); step(); step();
    step(); step(); step();
    checks++;
    if (bus.gnt !== 8'h01) begin
      errors++; $display("FAIL race_held: gnt=%h want 01", bus.gnt);
    end
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.timeout_err !== 1'b0 ||
        bus.bus_busy !== 1'b1) begin
      errors++;
      $display("FAIL race_release: gnt=%h terr=%b busy=%b want 00 0 1",
               bus.gnt, bus.timeout_err, bus.bus_busy);
    end
    bus.req = 8'h01;
    #1;
    checks++;
    if (bus.pri_req !== 8'h01) begin
      errors++; $display("FAIL race_nolock: got %h want 01", bus.pri_req);
    end
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.timeout_err !== 1'b0 || bus.bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL race_idle: terr=%b busy=%b want 0 0",
               bus.timeout_err, bus.bus_busy);
    end
  endtask

  task automatic test_drop();
    bus.req = 8'h02;
    step();
    bus.req = 8'h00;
    step(); step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_sample: gnt=%h busy=%b want 00 0",
               bus.gnt, bus.bus_busy);
    end
    bus.req = 8'h02;
    step(); step();
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_check: gnt=%h busy=%b want 00 0",
               bus.gnt, bus.bus_busy);
    end
  endtask

  task automatic test_multihot();
    force_on = 1'b1;
    force_val = 8'h03;
    bus.req = 8'h03;
    step(); step();
    checks++;
    if (bus.bus_busy !== 1'b1) begin
      errors++; $display("FAIL mh_check: busy=%b want 1", bus.bus_busy);
    end
    bus.req = 8'h00;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.bus_busy !== 1'b0) begin
      errors++;
      $display("FAIL mh_reject: gnt=%h busy=%b want 00 0",
               bus.gnt, bus.bus_busy);
    end
    force_on = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    bus.req = 8'h10;
    step(); step(); step();
    checks++;
    if (bus.gnt !== 8'h10) begin
      errors++; $display("FAIL rmid_grant: gnt=%h want 10", bus.gnt);
    end
    reset = 1'b1;
    step();
    checks++;
    if (bus.gnt !== 8'h00 || bus.bus_busy !== 1'b0 ||
        bus.owner !== 3'd0) begin
      errors++;
      $display("FAIL rmid_reset: gnt=%h busy=%b owner=%0d want 00 0 0",
               bus.gnt, bus.bus_busy, bus.owner);
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.pri_en !== 1'b1) begin
      errors++; $display("FAIL rmid_restart: en=%b want 1", bus.pri_en);
    end
    step(); step();
    checks++;
    if (bus.gnt !== 8'h10 || bus.owner !== 3'd4) begin
      errors++;
      $display("FAIL rmid_regrant: gnt=%h owner=%0d want 10 4",
               bus.gnt, bus.owner);
    end
    bus.req = 8'h00;
    step(); step();
  endtask

  task automatic test_random();
    logic [7:0] r, elig, exp_g;
    logic [2:0] oi;
    int d;
    for (int it = 0; it < 40; it++) begin
      r = 8'($urandom);
      bus.req = r;
      elig = r & ~tb_lock;
      #1;
      checks++;
      if (bus.pri_req !== elig) begin
        errors++;
        $display("FAIL rnd_prireq it%0d: got %h want %h",
                 it, bus.pri_req, elig);
      end
      if (elig == 8'h00) begin
        step(); step();
        checks++;
        if (bus.gnt !== 8'h00 || bus.bus_busy !== 1'b0) begin
          errors++;
          $display("FAIL rnd_nogrant it%0d: gnt=%h busy=%b",
                   it, bus.gnt, bus.bus_busy);
        end
        continue;
      end
      exp_g = elig & (~elig + 8'd1);
      oi = idx_of(exp_g);
      step(); step(); step();
      checks++;
      if (bus.gnt !== exp_g || bus.owner !== oi) begin
        errors++;
        $display("FAIL rnd_grant it%0d: gnt=%h owner=%0d want %h %0d",
                 it, bus.gnt, bus.owner, exp_g, oi);
      end
      d = int'($urandom_range(1, 6));
      for (int k = 1; k <= 6; k++) begin
        if (k == d) bus.req[oi] = 1'b0;
        step();
        if (k == d) begin
          checks++;
          if (bus.gnt !== 8'h00 || bus.timeout_err !== 1'b0) begin
            errors++;
            $display("FAIL rnd_release it%0d k%0d: gnt=%h terr=%b",
                     it, k, bus.gnt, bus.timeout_err);
          end
          break;
        end else if (k == TMO) begin
          checks++;
          if (bus.gnt !== 8'h00 || bus.timeout_err !== 1'b1) begin
            errors++;
            $display("FAIL rnd_timeout it%0d: gnt=%h terr=%b want 00 1",
                     it, bus.gnt, bus.timeout_err);
          end
          tb_lock[oi] = 1'b1;
          break;
        end else begin
          checks++;
          if (bus.gnt !== exp_g) begin
            errors++;
            $display("FAIL rnd_hold it%0d k%0d: gnt=%h want %h",
                     it, k, bus.gnt, exp_g);
          end
        end
      end
      step();
      checks++;
      if (bus.bus_busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
        errors++;
        $display("FAIL rnd_idle it%0d: busy=%b terr=%b want 0 0",
                 it, bus.bus_busy, bus.timeout_err);
      end
    end
    bus.req = 8'h00;
    step(); step(); step();
  endtask

  initial begin
    bus.req = 8'h00;
    test_reset();
    test_single();
    test_simultaneous();
    test_timeout();
    test_release_at_timeout();
    test_drop();
    test_multihot();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bus_grant_ctrl.md
# bus_grant_ctrl

Bus grant controller sitting directly downstream of the bus priority generator. It collects raw master requests, masks locked-out masters, strobes the priority generator's enable, validates the registered one-hot result, and then holds a bus grant until the owner releases or a hold timeout expires. It drives the generator's `pri_in`/`en` inputs and consumes its `pri_out`.

## Interface
- `TIMEOUT_CYCLES`, 64: maximum cycles a master may hold the bus; 0 disables the timeout.
- `CNT_W`, 8: width of the hold counter; must satisfy `TIMEOUT_CYCLES` ≤ 2^`CNT_W`.
- `clk`, in, 1: clock; all logic on the rising edge.
- `reset`, in, 1: reset; synchronous, active-high.
- `req`, in, 8: raw request per master; bit 0 has the highest priority. A master releases the bus by deasserting its bit.
- `pri_req`, out, 8: `req & ~lockout`; drives the generator's `pri_in`. Combinational.
- `pri_en`, out, 1: generator enable; high only in state SAMPLE. Combinational from state.
- `pri_onehot`, in, 8: registered generator output (`pri_out`).
- `gnt`, out, 8: registered one-hot grant; all zero when no owner.
- `owner`, out, 3: registered binary index of the granted master; holds its last value when `gnt` is 0.
- `bus_busy`, out, 1: registered; high in CHECK, OWNED and RELEASE.
- `timeout_err`, out, 1: registered one-cycle pulse when an owner is forcibly released.

## Operation
- States: IDLE, SAMPLE, CHECK, OWNED, RELEASE.
- IDLE: if `|pri_req`, go to SAMPLE; otherwise stay.
- SAMPLE: `pri_en`=1 for exactly one cycle, so the generator captures `pri_req`. Always go to CHECK.
- CHECK: test `pri_onehot` for validity.
  - Valid means exactly one bit is set and that bit is still set in `pri_req`.
  - If valid: load `gnt` with `pri_onehot`, load `owner` with its index, clear the counter, go to OWNED.
  - Otherwise (zero, multi-hot, or requester dropped): go to IDLE with no grant.
- OWNED: the counter increments every cycle, saturating at its maximum.
  - If `req[owner]` is 0: go to RELEASE.
  - Else if `TIMEOUT_CYCLES` ≠ 0 and the counter equals `TIMEOUT_CYCLES-1`: go to RELEASE, pulse `timeout_err`, set `lockout[owner]`.
  - If both hold in the same cycle, the release path wins and there is no `timeout_err` and no lockout.
- RELEASE: `gnt` is 0 (one dead cycle for bus turnaround). Always go to IDLE.
- Lockout: an 8-bit register. Each bit clears in any cycle where the corresponding `req` bit is 0. A bit is never both set and cleared in one cycle, because a timeout requires `req[owner]`=1.
- Requests from other masters during OWNED are ignored; no preemption.
- `req[owner]` changes during CHECK are covered by the validity test.

## Timing
- Reset (synchronous): state IDLE, `gnt`=0, `owner`=0, `bus_busy`=0, `timeout_err`=0, lockout=0, counter=0. `pri_en` is therefore 0.
- Reset mid-grant: `gnt` is 0 after the reset edge; the generator's stale `pri_out` is ignored until the next CHECK.
- Grant latency: `req` is first high at edge E0.
  - E0: enter SAMPLE.
  - E1: generator captures; enter CHECK.
  - E2: `gnt` asserts.
  - This is 2 cycles from SAMPLE and 3 edges from first sight.
- Release latency: `req[owner]` is seen low at edge Er.
  - Er: `gnt`=0 and RELEASE.
  - Er+1: IDLE.
  - Er+2: earliest next SAMPLE.
  - Earliest next grant is at Er+4.
- Timeout: `gnt` is high for exactly `TIMEOUT_CYCLES` cycles. `timeout_err` is high during the RELEASE cycle only.
- `bus_busy` rises at the edge entering CHECK and falls at the edge entering IDLE.

## Test plan
- Single request: `req`=8'h04 from idle → `pri_en` high for 1 cycle, `gnt`=8'h04 and `owner`=2 on the 3rd edge. Then `req`=0 → `gnt`=0 next edge, RELEASE, IDLE.
- Simultaneous requests: `req`=8'hA6 → `gnt`=8'h02. Master 1 drops → one dead cycle, then `gnt`=8'h04 four edges after the drop.
- Timeout with `TIMEOUT_CYCLES`=4: master 0 holds its request → `gnt`=8'h01 for exactly 4 cycles, `timeout_err` pulse, `lockout[0]`=1, master 3 granted next. Master 0 drops and re-asserts → it is eligible again and wins the next arbitration.
- Release on the same cycle as the timeout count → no `timeout_err`, lockout stays 0.
- Requester drops during SAMPLE/CHECK, and a forced multi-hot `pri_onehot`=8'h03 → no grant, return to IDLE, `bus_busy` falls.
- Reset asserted while `gnt`=8'h10 → `gnt`=0, `bus_busy`=0, `owner`=0 after the reset edge. After reset deasserts, arbitration restarts from IDLE.
